// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty ramp generator.
package pwm_pkg;

  localparam int unsigned PWM_N    = 8;
  localparam int unsigned DUTY_MAX = (1 << PWM_N) - 1;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HIGH,
    RAMP_DOWN,
    HOLD_LOW
  } ramp_state_t;

  // Adds one bit of headroom so the sum cannot wrap before it is clamped to 2^w-1.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b);
    return (b > a) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides clk down to a one-cycle registered step strobe every prescale+1 cycles.
module step_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  step
);

  logic [PRESCALE_W-1:0] cnt;

  // The all-ones wrap keeps the counter moving if prescale drops below the current count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (!ena) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (cnt == prescale || cnt == '1) begin
      cnt  <= '0;
      step <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      step <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Triangle duty sweep for a downstream PWM; duty changes only on PWM period boundaries.
// Define PWM_DUTY_RAMP_GAMMA_EN for a registered squared (gamma) duty output.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned N          = PWM_N,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned HOLD_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [N-1:0]          inc,
  input  logic [HOLD_W-1:0]     hold,
  output logic                  step,
  output logic [N-1:0]          duty,
  output logic                  busy,
  output logic                  done
);

  localparam logic [N-1:0] LEVEL_MAX = '1;

  ramp_state_t       state, state_n;
  logic [N-1:0]      pcnt;
  logic              period_end;
  logic [N-1:0]      level, level_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [N-1:0]      inc_l, inc_n;
  logic [HOLD_W-1:0] hold_l, hold_n;
  logic              cont_l, cont_n;
  logic              done_n;

  step_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .prescale (prescale),
    .step     (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pcnt <= '0;
    else if (!ena)    pcnt <= '0;
    else if (step)    pcnt <= pcnt + 1'b1;
  end

  assign period_end = step && (pcnt == '1);

  always_comb begin
    state_n    = state;
    level_n    = level;
    hold_cnt_n = hold_cnt;
    inc_n      = inc_l;
    hold_n     = hold_l;
    cont_n     = cont_l;
    done_n     = 1'b0;
    if (!ena) begin
      state_n    = IDLE;
      level_n    = '0;
      hold_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = RAMP_UP;
            inc_n   = (inc == '0) ? N'(1) : inc;
            hold_n  = hold;
            cont_n  = continuous;
          end
        end
        RAMP_UP: begin
          if (period_end) begin
            level_n = N'(sat_add(32'(level), 32'(inc_l), N));
            if (level_n == LEVEL_MAX) begin
              hold_cnt_n = hold_l;
              state_n    = HOLD_HIGH;
            end
          end
        end
        HOLD_HIGH: begin
          if (period_end) begin
            if (hold_cnt == '0) state_n    = RAMP_DOWN;
            else                hold_cnt_n = hold_cnt - 1'b1;
          end
        end
        RAMP_DOWN: begin
          if (period_end) begin
            level_n = N'(sat_sub(32'(level), 32'(inc_l)));
            if (level_n == '0) begin
              hold_cnt_n = hold_l;
              state_n    = HOLD_LOW;
            end
          end
        end
        HOLD_LOW: begin
          if (period_end) begin
            if (hold_cnt != '0) begin
              hold_cnt_n = hold_cnt - 1'b1;
            end else if (cont_l) begin
              state_n = RAMP_UP;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // busy follows the next state so it drops in the same cycle the state returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      level    <= '0;
      hold_cnt <= '0;
      inc_l    <= '0;
      hold_l   <= '0;
      cont_l   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      level    <= level_n;
      hold_cnt <= hold_cnt_n;
      inc_l    <= inc_n;
      hold_l   <= hold_n;
      cont_l   <= cont_n;
      done     <= done_n;
      busy     <= (state_n != IDLE);
    end
  end

`ifdef PWM_DUTY_RAMP_GAMMA_EN
  logic [2*N-1:0] sq;
  logic [N-1:0]   duty_q;

  assign sq = {{N{1'b0}}, level} * {{N{1'b0}}, level};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    duty_q <= '0;
    else if (!ena)              duty_q <= '0;
    else if (level == LEVEL_MAX) duty_q <= LEVEL_MAX;
    else                        duty_q <= N'(sq >> N);
  end

  assign duty = duty_q;
`else
  assign duty = level;
`endif

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: prescaler, sweeps, saturation, abort, continuous, reset.
module tb_pwm_duty_ramp;

`ifdef PWM_DUTY_RAMP_GAMMA_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        start;
  logic        continuous;
  logic [15:0] prescale;
  logic [7:0]  inc;
  logic [7:0]  hold;
  logic        step;
  logic [7:0]  duty;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  pwm_duty_ramp #(.N(8), .PRESCALE_W(16), .HOLD_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .continuous (continuous),
    .prescale   (prescale),
    .inc        (inc),
    .hold       (hold),
    .step       (step),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  function automatic logic [7:0] g(input logic [7:0] l);
`ifdef PWM_DUTY_RAMP_GAMMA_EN
    logic [15:0] sq;
    sq = {8'h00, l} * {8'h00, l};
    return (l == 8'hFF) ? 8'hFF : sq[15:8];
`else
    return l;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_duty(input int budget, output int cyc);
    logic [7:0] prev;
    prev = duty;
    cyc  = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (duty !== prev) return;
    end
    cyc = -1;
  endtask

  task automatic expect_change(input string tag, input int exp_cyc, input logic [7:0] exp_duty);
    int c;
    wait_duty(exp_cyc + 50, c);
    check({tag, " interval"}, c, exp_cyc);
    check({tag, " duty"}, duty, exp_duty);
  endtask

  task automatic expect_value(input string tag, input logic [7:0] exp_duty);
    int c;
    wait_duty(1200, c);
    check({tag, " duty"}, duty, exp_duty);
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int c;
    c = 0;
    while (c < exp_cyc + 50) begin
      @(negedge clk);
      c++;
      if (done === 1'b1) break;
    end
    check({tag, " done delay"}, c, exp_cyc);
    check({tag, " busy at done"}, busy, 0);
    @(negedge clk);
    check({tag, " done width"}, done, 0);
  endtask

  task automatic go_idle();
    @(negedge clk);
    ena   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic begin_sweep(input logic [7:0] i, input logic [7:0] h, input logic c);
    @(negedge clk);
    prescale   = 16'd0;
    inc        = i;
    hold       = h;
    continuous = c;
    ena        = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int d0;
    rst = 1'b1; ena = 1'b0; start = 1'b0; continuous = 1'b0;
    prescale = 16'd0; inc = 8'd0; hold = 8'd0;
    repeat (3) @(negedge clk);
    check("reset duty", duty, 0);
    check("reset step", step, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst = 1'b0;

    // prescale=3: first step 4 cycles after ena, then 1 in 4
    @(negedge clk);
    prescale = 16'd3;
    ena      = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check($sformatf("ps3 step c%0d", i), step, (i % 4 == 0) ? 1 : 0);
    end
    check("ps3 idle busy", busy, 0);
    ena = 1'b0;
    @(negedge clk);
    check("ena low step", step, 0);
    prescale = 16'd0;
    ena      = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("ps0 step c%0d", i), step, 1);
    end
    go_idle();

    // single sweep inc=0x40 hold=1
    d0 = done_seen;
    begin_sweep(8'h40, 8'd1, 1'b0);
    check("sweep busy", busy, 1);
    expect_change("sw 40", 256 + LAT, g(8'h40));
    expect_change("sw 80", 256, g(8'h80));
    expect_change("sw C0", 256, g(8'hC0));
    expect_change("sw FF", 256, g(8'hFF));
    expect_change("sw BF", 768, g(8'hBF));
    expect_change("sw 7F", 256, g(8'h7F));
    expect_change("sw 3F", 256, g(8'h3F));
    expect_change("sw 00", 256, 8'h00);
    wait_done("sw", 512 - LAT);
    #1;
    check("sw done count", done_seen - d0, 1);
    go_idle();

`ifndef PWM_DUTY_RAMP_GAMMA_EN
    begin_sweep(8'h00, 8'd0, 1'b0);
    expect_change("inc0 01", 256, 8'h01);
    expect_change("inc0 02", 256, 8'h02);
    go_idle();
    check("inc0 idle duty", duty, 0);
`endif

    d0 = done_seen;
    begin_sweep(8'hFF, 8'd0, 1'b0);
    expect_change("incFF up", 256 + LAT, 8'hFF);
    expect_change("incFF dn", 512, 8'h00);
    wait_done("incFF", 256 - LAT);
    #1;
    check("incFF done count", done_seen - d0, 1);
    go_idle();

    // start while busy ignored; ena drop in HOLD_HIGH aborts silently
    begin_sweep(8'h40, 8'd0, 1'b0);
    repeat (5) @(negedge clk);
    inc = 8'h10; hold = 8'd5; continuous = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_value("ab 40", g(8'h40));
    expect_change("ab 80", 256, g(8'h80));
    expect_change("ab C0", 256, g(8'hC0));
    expect_change("ab FF", 256, g(8'hFF));
    repeat (10) @(negedge clk);
    d0    = done_seen;
    ena   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort duty", duty, 0);
    check("abort busy", busy, 0);
    check("abort step", step, 0);
    repeat (600) @(negedge clk);
    #1;
    check("abort no done", done_seen - d0, 0);
    check("abort stays idle", busy, 0);
    go_idle();

    // continuous: three triangles without done
    d0 = done_seen;
    begin_sweep(8'h80, 8'd0, 1'b1);
    for (int t = 0; t < 3; t++) begin
      expect_change($sformatf("ct%0d 80", t), (t == 0) ? 256 + LAT : 512, g(8'h80));
      expect_change($sformatf("ct%0d FF", t), 256, 8'hFF);
      expect_change($sformatf("ct%0d 7F", t), 512, g(8'h7F));
      expect_change($sformatf("ct%0d 00", t), 256, 8'h00);
    end
    #1;
    check("cont no done", done_seen - d0, 0);
    check("cont busy", busy, 1);
    go_idle();

    // async reset in RAMP_DOWN at level 0x80
    begin_sweep(8'h7F, 8'd0, 1'b0);
    expect_value("rs 7F", g(8'h7F));
    expect_value("rs FE", g(8'hFE));
    expect_value("rs FF", 8'hFF);
    expect_value("rs 80", g(8'h80));
    #2 rst = 1'b1;
    #1;
    check("mid rst duty", duty, 0);
    check("mid rst step", step, 0);
    check("mid rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("post rst busy", busy, 0);
    check("post rst duty", duty, 0);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
